// File: rtl/async_fifo_pkg.sv
// Shared types and defaults for the async FIFO read-side controller.
package async_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int DSIZE_DEF     = 8;
  localparam int BURST_LEN_DEF = 4;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry {data, last} output buffer. The head entry drives the stream
// outputs directly from flops, so they stay stable while stalled.
module rd_skid_buf
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic             head_valid,
  output logic [DSIZE-1:0] head_data,
  output logic             head_last,
  output logic [1:0]       count
);

  logic [DSIZE-1:0] tail_data;
  logic             tail_last;
  logic             tail_valid;

  assign count = 2'(head_valid) + 2'(tail_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      head_last  <= 1'b0;
      tail_valid <= 1'b0;
      tail_data  <= '0;
      tail_last  <= 1'b0;
    end else if (pop) begin
      if (tail_valid) begin
        head_data  <= tail_data;
        head_last  <= tail_last;
        head_valid <= 1'b1;
        tail_valid <= push;
        if (push) begin
          tail_data <= push_data;
          tail_last <= push_last;
        end
      end else if (push) begin
        head_data  <= push_data;
        head_last  <= push_last;
        head_valid <= 1'b1;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (push) begin
      // Fill head first; the controller never pushes into a full buffer.
      if (!head_valid) begin
        head_data  <= push_data;
        head_last  <= push_last;
        head_valid <= 1'b1;
      end else begin
        tail_data  <= push_data;
        tail_last  <= push_last;
        tail_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller: pops the async FIFO into a valid/ready stream in
// fixed-length bursts. Optional word counter enabled by RD_CTRL_STATS_EN.
//
// state | meaning
// IDLE  | no burst in progress, buffer empty
// BURST | popping words of the current burst
// DRAIN | burst fully popped, waiting for buffer to empty
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  output logic             busy
`ifdef RD_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] word_cnt
`endif
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  rd_state_e       state;
  rd_state_e       state_next;
  logic [BW-1:0]   beat_cnt;
  logic            beat_last;
  logic            hs;
  logic [1:0]      count;

  assign hs        = m_valid && m_ready;
  assign beat_last = (beat_cnt == LAST_BEAT);
  // A full buffer can still accept a word when the head leaves this cycle.
  assign rinc      = !rempty && (state != DRAIN) && ((count != 2'd2) || hs);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rinc) state_next = BURST;
      BURST:   if (rinc && beat_last) state_next = DRAIN;
      DRAIN:   if ((count == 2'd0) || ((count == 2'd1) && hs)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      beat_cnt <= '0;
    end else if (rinc) begin
      beat_cnt <= beat_last ? '0 : beat_cnt + BW'(1);
    end
  end

  rd_skid_buf #(
    .DSIZE(DSIZE)
  ) u_skid (
    .clk       (rclk),
    .rst       (rrst),
    .push      (rinc),
    .push_data (rdata),
    .push_last (beat_last),
    .pop       (hs),
    .head_valid(m_valid),
    .head_data (m_data),
    .head_last (m_last),
    .count     (count)
  );

`ifdef RD_CTRL_STATS_EN
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      word_cnt <= '0;
    end else if (hs) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/async_fifo_rd_ctrl.md
# async_fifo_rd_ctrl

Read-side controller for the async FIFO, running in the read clock domain. It pops words from the FIFO's read port (`rinc`/`rempty`/`rdata`) and presents them to a downstream consumer on a valid/ready stream. Words are grouped into fixed-length bursts, and the last word of each burst is tagged. A 2-entry output buffer lets the FIFO be drained at one word per cycle under full downstream throughput.

## Interface
Parameters:
- `DSIZE`, default 8: data width; must equal the FIFO data width.
- `BURST_LEN`, default 4: words per burst; legal range 2..256.
- `CNT_W`, default 16: width of the statistics counter (used only with `RD_CTRL_STATS_EN`).

Ports:
- `rclk`  in  1: read-domain clock; all logic is on the rising edge.
- `rrst`  in  1: reset, asynchronous, active-high; deassertion must be synchronous to `rclk` upstream.
- `rempty`  in  1: FIFO empty flag, already in the `rclk` domain.
- `rdata`  in  DSIZE: FIFO head word; combinationally valid whenever `rempty`=0.
- `rinc`  out  1: FIFO pop strobe; one word is consumed per `rclk` edge while high.
- `m_valid`  out  1: output word valid.
- `m_ready`  in  1: downstream accepts.
- `m_data`  out  DSIZE: output word.
- `m_last`  out  1: `m_data` is the final word of its burst.
- `busy`  out  1: state is not IDLE.
- `word_cnt`  out  CNT_W: accepted-word count; present only with `RD_CTRL_STATS_EN`.

## Operation
- FSM states: IDLE, BURST, DRAIN. Reset state is IDLE.
- IDLE→BURST: on the first pop.
- BURST→DRAIN: on the edge that pops the `BURST_LEN`-th word of the burst.
- DRAIN→IDLE: when the buffer is empty. This includes the same edge on which the last buffered word is accepted.
- `rinc` = `!rempty` && state≠DRAIN && (buffered entries < 2, or an output handshake occurs this cycle). It is combinational, so a word can be popped in the same cycle the buffer frees.
- No pop ever occurs while `rempty`=1 (no underflow under any input pattern).
- On an edge with `rinc`=1, `rdata` is written to the buffer tail together with a last flag. The flag is 1 when `beat_cnt`==`BURST_LEN`-1.
- `beat_cnt` increments per pop and wraps to 0 after `BURST_LEN`.
- Output handshake: a word transfers on an edge with `m_valid`&&`m_ready`.
- While `m_valid`=1 and `m_ready`=0, `m_data`/`m_last` hold stable.
- `rempty` rising mid-burst pauses the burst: state stays BURST and `beat_cnt` holds. Burst boundaries are never shortened.
- DRAIN enforces a gap: the next burst's first word never enters the buffer while the previous burst's words are still buffered.
- Simultaneous pop and handshake with 2 entries buffered: head leaves, tail moves to head, new word enters the tail. Occupancy stays 2.
- Reset mid-operation: buffered words are discarded, `beat_cnt`=0, state IDLE. Words already popped are lost; the FIFO keeps its remaining contents.

## Timing
- Reset values: `rinc` reflects `!rempty` (combinational; buffer empty, IDLE); `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `word_cnt`=0.
- Latency: a word popped at edge N is on `m_data` with `m_valid`=1 in the cycle after edge N.
- Throughput: 1 word/cycle within a burst when `rempty`=0 and `m_ready`=1.
- Inter-burst gap: at least 1 cycle with `rinc`=0 after each burst (the DRAIN state).
- `m_data`, `m_valid`, `m_last` and `busy` are register outputs. Only `rinc` is combinational.

## Configuration
- `RD_CTRL_STATS_EN` defined: `word_cnt` port exists. It increments on every output handshake and wraps modulo 2^CNT_W. Reset value is 0.
- `RD_CTRL_STATS_EN` undefined: no `word_cnt` port and no counter logic. All other behaviour is identical.

## Structure
- Shared package `async_fifo_pkg`:
  - `rd_state_e` enum (IDLE, BURST, DRAIN);
  - `DSIZE_DEF`=8;
  - `BURST_LEN_DEF`=4.
- Sub-module `rd_skid_buf`: 2-entry buffer of {data, last} with push/pop/count.
- The FSM, beat counter and `rinc` logic stay in the top.

## Test plan
- Reset with the FIFO preloaded with 0x01..0x04 and `m_ready`=1 → `rinc` high for 4 consecutive cycles; `m_data` 0x01..0x04 on consecutive cycles; `m_last`=1 only with 0x04; `busy` returns to 0.
- 8 words preloaded, `m_ready` held 0 → exactly 2 pops, then `rinc`=0 with `m_data`=0x01 stable. Release `m_ready` → words in order; `m_last` on 0x04 and 0x08; `rinc`=0 for at least 1 cycle between 0x04 and 0x05.
- `rempty` forced to 1 after 2 words of a burst, for 5 cycles → no `rinc` while empty. The next 2 words complete the burst, and `m_last` is on the 4th word overall.
- Random `m_ready` (50%) over 64 words → output sequence equals input sequence; every 4th word has `m_last`=1; no pop while `rempty`=1.
- `rrst` asserted mid-burst with 2 words buffered → same cycle `m_valid`=0, `busy`=0. After release, the next popped word has `beat_cnt` restarted, so `m_last` falls on the 4th word after reset.
- With `RD_CTRL_STATS_EN`, CNT_W=4, 20 handshakes → `word_cnt`=4 (wrap).
